fft_peak_tracker: RTL and testbench



---
 rtl/fft_peak_tracker_pkg.sv | 28 ++
 rtl/fft_peak_tracker_if.sv | 26 ++
 rtl/fft_peak_tracker_sort.sv | 52 +++++
 rtl/fft_peak_tracker.sv | 127 ++++++++++++
 tb/tb_fft_peak_tracker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_peak_tracker_pkg.sv
// Shared sizes, the peak list entry type and helpers for the spectral peak tracker.
package fft_peak_tracker_pkg;

  localparam int unsigned W            = 33;
  localparam int unsigned NSamples     = 1024;
  localparam int unsigned NPeaks       = 4;
  localparam int unsigned KMin         = 2;
  localparam int unsigned KMax         = 511;
  localparam int unsigned Tol          = 2;
  localparam int unsigned StableFrames = 3;

  localparam int unsigned KW = $clog2(NSamples);
  localparam int unsigned CW = $clog2(NPeaks + 1);
  localparam int unsigned SW = $clog2(StableFrames);

  typedef struct packed {
    logic [KW-1:0] k;
    logic [W-1:0]  mag;
  } peak_entry_t;

  // |a - b| evaluated in KW+1 signed bits.
  function automatic logic [KW:0] abs_diff(input logic [KW-1:0] a, input logic [KW-1:0] b);
    logic signed [KW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[KW] ? -d : d;
  endfunction

endpackage

// File: rtl/fft_peak_tracker_if.sv
// Bin stream in, sorted peak result out; master is the producer/consumer side.
interface fft_peak_tracker_if;
  import fft_peak_tracker_pkg::*;

  logic [W-1:0]         mag;
  logic                 mag_valid;
  logic [W-1:0]         threshold;
  logic [NPeaks*KW-1:0] peak_k;
  logic [NPeaks*W-1:0]  peak_mag;
  logic [CW-1:0]        peak_count;
  logic                 peak_valid;
  logic                 peak_ready;
  logic                 fire;
  logic                 frame_overrun;

  modport master (
    output mag, mag_valid, threshold, peak_ready,
    input  peak_k, peak_mag, peak_count, peak_valid, fire, frame_overrun
  );

  modport slave (
    input  mag, mag_valid, threshold, peak_ready,
    output peak_k, peak_mag, peak_count, peak_valid, fire, frame_overrun
  );

endinterface

// File: rtl/fft_peak_tracker_sort.sv
// Registered NPeaks-entry list sorted by descending magnitude with single-cycle insertion.
module fft_peak_tracker_sort
  import fft_peak_tracker_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ins_i,
  input  peak_entry_t              entry_i,
  input  logic                     clear_i,
  output peak_entry_t [NPeaks-1:0] snap_o,
  output logic [CW-1:0]            snap_cnt_o
);

  peak_entry_t [NPeaks-1:0] list_q, list_d, next;
  logic [CW-1:0]            cnt_q, cnt_d, next_cnt;
  int                       pos;

  always_comb begin
    next     = list_q;
    next_cnt = cnt_q;
    pos      = int'(NPeaks);
    if (ins_i) begin
      // Strictly-less compare keeps earlier bins ahead on equal magnitude.
      for (int i = int'(NPeaks) - 1; i >= 0; i--) begin
        if (i >= int'(cnt_q) || list_q[i].mag < entry_i.mag) pos = i;
      end
      for (int i = int'(NPeaks) - 1; i > 0; i--) begin
        if (i > pos) next[i] = list_q[i-1];
      end
      for (int i = 0; i < int'(NPeaks); i++) begin
        if (i == pos) next[i] = entry_i;
      end
      if (pos < int'(NPeaks) && cnt_q < CW'(NPeaks)) next_cnt = cnt_q + 1'b1;
    end
    list_d = clear_i ? '0 : next;
    cnt_d  = clear_i ? '0 : next_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      list_q <= '0;
      cnt_q  <= '0;
    end else begin
      list_q <= list_d;
      cnt_q  <= cnt_d;
    end
  end

  assign snap_o     = next;
  assign snap_cnt_o = next_cnt;

endmodule

// File: rtl/fft_peak_tracker.sv
// Band-limited multi-peak tracker: bin counter, frame publish/handshake and pitch stability.
module fft_peak_tracker
  import fft_peak_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fft_peak_tracker_if.slave bus
);

  localparam logic [KW-1:0] KMinK     = KW'(KMin);
  localparam logic [KW-1:0] KMaxK     = KW'(KMax);
  localparam logic [KW-1:0] KLast     = KW'(NSamples - 1);
  localparam logic [KW:0]   TolK      = (KW + 1)'(Tol);
  localparam logic [SW-1:0] StableTop = SW'(StableFrames - 1);

  logic [KW-1:0]            k_q;
  logic                     publish, qual, match;
  peak_entry_t              entry;
  peak_entry_t [NPeaks-1:0] snap;
  logic [CW-1:0]            snap_cnt;
  logic [NPeaks*KW-1:0]     snap_k;
  logic [NPeaks*W-1:0]      snap_mag;

  logic [NPeaks*KW-1:0] peak_k_q, peak_k_d;
  logic [NPeaks*W-1:0]  peak_mag_q, peak_mag_d;
  logic [CW-1:0]        peak_count_q, peak_count_d;
  logic                 peak_valid_q, peak_valid_d;
  logic                 fire_q, fire_d;
  logic                 overrun_q, overrun_d;
  logic [KW-1:0]        prev_k0_q, prev_k0_d;
  logic                 prev_nz_q, prev_nz_d;
  logic [SW-1:0]        stable_q, stable_d;
  logic                 armed_q, armed_d;

  assign publish = bus.mag_valid && (k_q == KLast);
  assign qual    = bus.mag_valid && (k_q >= KMinK) && (k_q <= KMaxK) &&
                   (bus.mag > bus.threshold);
  assign entry   = '{k: k_q, mag: bus.mag};

  // The last bin is inserted and the list cleared in the same cycle it is snapshotted.
  fft_peak_tracker_sort u_sort (
    .clk        (clk),
    .reset      (reset),
    .ins_i      (qual),
    .entry_i    (entry),
    .clear_i    (publish),
    .snap_o     (snap),
    .snap_cnt_o (snap_cnt)
  );

  always_comb begin
    for (int i = 0; i < int'(NPeaks); i++) begin
      snap_k[i*KW +: KW] = snap[i].k;
      snap_mag[i*W +: W] = snap[i].mag;
    end
  end

  assign match = (snap_cnt != '0) && prev_nz_q && (abs_diff(snap[0].k, prev_k0_q) <= TolK);

  always_comb begin
    peak_k_d     = peak_k_q;
    peak_mag_d   = peak_mag_q;
    peak_count_d = peak_count_q;
    peak_valid_d = peak_valid_q && !bus.peak_ready;
    fire_d       = 1'b0;
    overrun_d    = 1'b0;
    prev_k0_d    = prev_k0_q;
    prev_nz_d    = prev_nz_q;
    stable_d     = stable_q;
    armed_d      = armed_q;
    if (publish) begin
      peak_k_d     = snap_k;
      peak_mag_d   = snap_mag;
      peak_count_d = snap_cnt;
      peak_valid_d = 1'b1;
      overrun_d    = peak_valid_q && !bus.peak_ready;
      prev_k0_d    = snap[0].k;
      prev_nz_d    = (snap_cnt != '0);
      if (match) begin
        if (stable_q != StableTop) stable_d = stable_q + 1'b1;
        if (stable_d == StableTop && armed_q) begin
          fire_d  = 1'b1;
          armed_d = 1'b0;
        end
      end else begin
        stable_d = '0;
        armed_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q          <= '0;
      peak_k_q     <= '0;
      peak_mag_q   <= '0;
      peak_count_q <= '0;
      peak_valid_q <= 1'b0;
      fire_q       <= 1'b0;
      overrun_q    <= 1'b0;
      prev_k0_q    <= '0;
      prev_nz_q    <= 1'b0;
      stable_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      if (bus.mag_valid) k_q <= k_q + 1'b1;
      peak_k_q     <= peak_k_d;
      peak_mag_q   <= peak_mag_d;
      peak_count_q <= peak_count_d;
      peak_valid_q <= peak_valid_d;
      fire_q       <= fire_d;
      overrun_q    <= overrun_d;
      prev_k0_q    <= prev_k0_d;
      prev_nz_q    <= prev_nz_d;
      stable_q     <= stable_d;
      armed_q      <= armed_d;
    end
  end

  assign bus.peak_k        = peak_k_q;
  assign bus.peak_mag      = peak_mag_q;
  assign bus.peak_count    = peak_count_q;
  assign bus.peak_valid    = peak_valid_q;
  assign bus.fire          = fire_q;
  assign bus.frame_overrun = overrun_q;

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed and randomized frames checked against a top-N selection model of the tracker.
module tb_fft_peak_tracker;
  import fft_peak_tracker_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_peak_tracker_if bus ();

  fft_peak_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] fr [NSamples];

  // Model state
  int                   m_prev_cnt, m_prev_k0, m_run, fire_seen;
  bit                   m_fired, m_pending;
  logic [NPeaks*KW-1:0] e_k, saved_k;
  logic [NPeaks*W-1:0]  e_mag;
  int                   e_cnt;
  bit                   e_fire, e_ovr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit r;
    r = bus.peak_ready;
    @(posedge clk);
    #1;
    if (r) m_pending = 0;
  endtask

  task automatic idle(input int n);
    bus.mag_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic fill(input int unsigned maxv);
    for (int k = 0; k < int'(NSamples); k++) fr[k] = W'($urandom_range(0, maxv));
  endtask

  // Top NPeaks of the qualifying bins, largest first, earlier bin first on ties.
  task automatic model_frame();
    bit taken [NSamples];
    int best, k0, d;
    bit match;
    for (int k = 0; k < int'(NSamples); k++) taken[k] = 0;
    e_k = '0;
    e_mag = '0;
    e_cnt = 0;
    for (int s = 0; s < int'(NPeaks); s++) begin
      best = -1;
      for (int k = int'(KMin); k <= int'(KMax); k++) begin
        if (!taken[k] && fr[k] > bus.threshold && (best < 0 || fr[k] > fr[best])) best = k;
      end
      if (best >= 0) begin
        taken[best] = 1;
        e_k[s*KW +: KW] = best[KW-1:0];
        e_mag[s*W +: W] = fr[best];
        e_cnt++;
      end
    end
    k0 = int'(e_k[KW-1:0]);
    d = k0 - m_prev_k0;
    if (d < 0) d = -d;
    match = e_cnt > 0 && m_prev_cnt > 0 && d <= int'(Tol);
    if (match) m_run++;
    else begin
      m_run = 0;
      m_fired = 0;
    end
    e_fire = match && m_run >= int'(StableFrames) - 1 && !m_fired;
    if (e_fire) m_fired = 1;
    m_prev_k0 = k0;
    m_prev_cnt = e_cnt;
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < int'(NSamples); k++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        bus.mag_valid = 1'b0;
        tick();
      end
      bus.mag = fr[k];
      bus.mag_valid = 1'b1;
      if (k == int'(NSamples) - 1) begin
        chk("valid_before_last", bus.peak_valid, m_pending);
        model_frame();
        e_ovr = m_pending && !bus.peak_ready;
      end
      tick();
    end
    m_pending = 1;
    chk("peak_valid", bus.peak_valid, 1);
    chk("peak_count", bus.peak_count, e_cnt);
    chk("peak_k", bus.peak_k, e_k);
    chk("peak_mag", bus.peak_mag, e_mag);
    chk("fire", bus.fire, e_fire);
    chk("frame_overrun", bus.frame_overrun, e_ovr);
    if (bus.fire) fire_seen++;
  endtask

  task automatic do_reset();
    bus.mag_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst_valid", bus.peak_valid, 0);
    chk("rst_count", bus.peak_count, 0);
    chk("rst_k", bus.peak_k, 0);
    chk("rst_mag", bus.peak_mag, 0);
    chk("rst_fire", bus.fire, 0);
    chk("rst_ovr", bus.frame_overrun, 0);
    reset = 1'b0;
    m_prev_cnt = 0;
    m_prev_k0 = 0;
    m_run = 0;
    m_fired = 0;
    m_pending = 0;
  endtask

  task automatic peak_frame(input int k0);
    fill(15);
    bus.threshold = W'(16);
    fr[$urandom_range(KMin, KMax)] = W'($urandom_range(256, 4096));
    fr[$urandom_range(KMin, KMax)] = W'($urandom_range(256, 4096));
    fr[k0] = W'(32'h0010_0000);
  endtask

  initial begin
    bus.mag = '0;
    bus.mag_valid = 1'b0;
    bus.threshold = '0;
    bus.peak_ready = 1'b1;
    reset = 1'b1;
    fire_seen = 0;
    do_reset();

    // Single peak above threshold
    fill(0);
    bus.threshold = W'(16);
    fr[100] = W'(32'h1000);
    send_frame(0);
    chk("t1_k0", bus.peak_k[KW-1:0], 100);
    chk("t1_mag0", bus.peak_mag[W-1:0], 32'h1000);
    idle(2);
    chk("t1_valid_drop", bus.peak_valid, 0);

    // Five candidates, tie ordering and drop of the smallest
    fill(0);
    bus.threshold = '0;
    fr[10] = W'(5); fr[20] = W'(9); fr[30] = W'(9); fr[40] = W'(7); fr[50] = W'(3);
    send_frame(0);
    chk("t2_order", bus.peak_k, {10'd10, 10'd40, 10'd30, 10'd20});
    chk("t2_count", bus.peak_count, 4);
    idle(1);

    // Band edges: bins 0, 1 and 600 excluded
    fill(0);
    bus.threshold = W'(16);
    fr[0] = W'(32'hFFFF_0000); fr[1] = W'(32'hFFFF_0000); fr[600] = W'(32'hFFFF_0000);
    fr[2] = W'(32'h50);
    send_frame(0);
    chk("t3_k0", bus.peak_k[KW-1:0], 2);
    chk("t3_count", bus.peak_count, 1);
    fill(16);
    send_frame(1);
    chk("t3_empty", bus.peak_count, 0);

    // Stability sequence
    fire_seen = 0;
    peak_frame(100); send_frame(0);
    peak_frame(101); send_frame(0);
    peak_frame(99);  send_frame(0);
    peak_frame(100); send_frame(0);
    peak_frame(200); send_frame(0);
    peak_frame(200); send_frame(0);
    peak_frame(200); send_frame(0);
    chk("t4_fire_total", fire_seen, 2);

    // Overrun with ready held low, then one transfer
    bus.peak_ready = 1'b0;
    peak_frame(300); send_frame(1);
    saved_k = e_k;
    idle(5);
    chk("t5_hold_valid", bus.peak_valid, 1);
    chk("t5_hold_k", bus.peak_k, saved_k);
    peak_frame(310); send_frame(1);
    chk("t5_overrun", bus.frame_overrun, 1);
    idle(1);
    chk("t5_ovr_pulse", bus.frame_overrun, 0);
    bus.peak_ready = 1'b1;
    tick();
    chk("t5_transfer", bus.peak_valid, 0);

    // Back-to-back frames, no idle across the boundary
    for (int k = 0; k < int'(NSamples); k++) fr[k] = W'($urandom());
    bus.threshold = W'(32'h8000_0000);
    send_frame(0);
    fill(15);
    bus.threshold = W'(16);
    fr[2] = W'(32'h700); fr[3] = W'(32'h600); fr[4] = W'(32'h700);
    send_frame(0);
    chk("t5_b2b_k", bus.peak_k[2*KW-1:0], {10'd4, 10'd2});

    // Heavy ties
    fill(15);
    bus.threshold = W'(10);
    send_frame(1);
    idle(3);

    // Reset mid-frame at bin 500
    fill(1000);
    for (int k = 0; k < 500; k++) begin
      bus.mag = fr[k];
      bus.mag_valid = 1'b1;
      tick();
    end
    do_reset();
    for (int k = 0; k < int'(NSamples); k++) fr[k] = {1'b0, $urandom()};
    bus.threshold = W'(32'h4000_0000);
    send_frame(1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
